// File: rtl/timer_bank_if.sv
// timer_bank_if: word-addressed register window plus interrupt outputs of timer_bank.
`default_nettype none

interface timer_bank_if #(
    parameter int CHANNELS = 2,
    parameter int CH_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    logic [CH_BITS+1:0]  addr;
    logic                we;
    logic [31:0]         wdata;
    logic [31:0]         rdata;
    logic [CHANNELS-1:0] irq;
    logic                irq_any;

    modport master (
        output addr, we, wdata,
        input  rdata, irq, irq_any
    );

    modport slave (
        input  addr, we, wdata,
        output rdata, irq, irq_any
    );
endinterface

`default_nettype wire

// File: rtl/timer_bank.sv
// ============================================================================
// Module      : timer_bank
// Description : CHANNELS independent one-shot / auto-reload / free-run timers
//               behind one register window; optional prescaler enabled by
//               defining TIMER_BANK_PRESCALE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_bank #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 32
) (
    input  wire logic clk,
    input  wire logic reset,
    timer_bank_if.slave bus
);
    localparam int CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_LOAD = 2'd1;
    localparam logic [1:0] C_CNT  = 2'd2;
    localparam logic [1:0] C_INT  = 2'd3;

    localparam logic [1:0] C_REG_CTRL   = 2'd0;
    localparam logic [1:0] C_REG_PRESET = 2'd1;
    localparam logic [1:0] C_REG_COUNT  = 2'd2;
    localparam logic [1:0] C_REG_STATUS = 2'd3;

    logic [CH_BITS-1:0]             w_ch;
    logic [1:0]                     w_reg;
    logic [CHANNELS-1:0][31:0]      w_rd_ch;
    logic [CHANNELS-1:0]            w_irq;
    logic [31:0]                    w_rdata;
    logic                           w_unused_wdata;

    assign w_ch           = bus.addr[CH_BITS+1:2];
    assign w_reg          = bus.addr[1:0];
    assign w_unused_wdata = ^bus.wdata;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            logic             r_en;
            logic [1:0]       r_mode;
            logic             r_im;
            logic [WIDTH-1:0] r_preset;
            logic [WIDTH-1:0] r_count;
            logic             r_pend;
            logic [1:0]       r_state;
            logic [1:0]       w_next_state;
            logic             w_sel;
            logic             w_wr_ctrl;
            logic             w_wr_preset;
            logic             w_w1c;
            logic             w_tick;
            logic             w_up;
            logic             w_load;
            logic             w_dec;
            logic             w_inc;
            logic             w_set_pend;
            logic             w_clr_en;
            logic [3:0]       w_ps_rd;
            logic [31:0]      w_rd_val;

            assign w_sel       = bus.we && (w_ch == CH_BITS'(i));
            assign w_wr_ctrl   = w_sel && (w_reg == C_REG_CTRL);
            assign w_wr_preset = w_sel && (w_reg == C_REG_PRESET);
            assign w_w1c       = w_sel && (w_reg == C_REG_STATUS) && bus.wdata[0];
            assign w_up        = (r_mode == 2'd2);

`ifdef TIMER_BANK_PRESCALE_EN
            logic [3:0]  r_ps;
            logic [14:0] r_psc;
            logic [15:0] w_ps_lim;

            assign w_ps_lim = (16'd1 << r_ps) - 16'd1;
            assign w_tick   = (r_psc == w_ps_lim[14:0]);
            assign w_ps_rd  = r_ps;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_ps  <= 4'd0;
                    r_psc <= 15'd0;
                end else begin
                    if (w_wr_ctrl) begin
                        r_ps <= bus.wdata[7:4];
                    end
                    if (w_load) begin
                        r_psc <= 15'd0;
                    end else if ((r_state == C_CNT) && r_en) begin
                        r_psc <= w_tick ? 15'd0 : r_psc + 15'd1;
                    end
                end
            end
`else
            assign w_tick  = 1'b1;
            assign w_ps_rd = 4'd0;
`endif

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_state <= C_IDLE;
                end else begin
                    r_state <= w_next_state;
                end
            end

            always_comb begin
                w_next_state = r_state;
                case (r_state)
                    C_IDLE: if (r_en) w_next_state = C_LOAD;
                    C_LOAD: w_next_state = C_CNT;
                    C_CNT: begin
                        if (!r_en) begin
                            w_next_state = C_IDLE;
                        end else if (w_tick && !w_up && (r_count == '0)) begin
                            w_next_state = C_INT;
                        end
                    end
                    default: w_next_state = (r_mode == 2'd1) ? C_LOAD : C_IDLE;
                endcase
            end

            always_comb begin
                w_load     = (r_state == C_LOAD);
                w_dec      = 1'b0;
                w_inc      = 1'b0;
                w_set_pend = 1'b0;
                w_clr_en   = (r_state == C_INT) && (r_mode != 2'd1);
                if ((r_state == C_CNT) && r_en && w_tick) begin
                    if (w_up) begin
                        w_inc      = 1'b1;
                        w_set_pend = (r_count == {WIDTH{1'b1}});
                    end else if (r_count == '0) begin
                        w_set_pend = 1'b1;
                    end else begin
                        w_dec      = 1'b1;
                    end
                end
            end

            // Software CTRL write takes priority over the one-shot EN clear
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_en     <= 1'b0;
                    r_mode   <= 2'd0;
                    r_im     <= 1'b0;
                    r_preset <= '0;
                    r_count  <= '0;
                    r_pend   <= 1'b0;
                end else begin
                    if (w_wr_ctrl) begin
                        r_en   <= bus.wdata[0];
                        r_mode <= bus.wdata[2:1];
                        r_im   <= bus.wdata[3];
                    end else if (w_clr_en) begin
                        r_en   <= 1'b0;
                    end
                    if (w_wr_preset) begin
                        r_preset <= bus.wdata[WIDTH-1:0];
                    end
                    if (w_load) begin
                        r_count <= r_preset;
                    end else if (w_dec) begin
                        r_count <= r_count - WIDTH'(1);
                    end else if (w_inc) begin
                        r_count <= r_count + WIDTH'(1);
                    end
                    if (w_set_pend) begin
                        r_pend <= 1'b1;
                    end else if (w_w1c) begin
                        r_pend <= 1'b0;
                    end
                end
            end

            always_comb begin
                w_rd_val = 32'd0;
                case (w_reg)
                    C_REG_CTRL:   w_rd_val = {24'd0, w_ps_rd, r_im, r_mode, r_en};
                    C_REG_PRESET: w_rd_val = 32'(r_preset);
                    C_REG_COUNT:  w_rd_val = 32'(r_count);
                    default:      w_rd_val = {31'd0, r_pend};
                endcase
            end

            assign w_rd_ch[i] = w_rd_val;
            assign w_irq[i]   = r_pend & r_im;
        end
    endgenerate

    // Channel indices at or above CHANNELS match no entry and read as zero
    always_comb begin
        w_rdata = 32'd0;
        for (int j = 0; j < CHANNELS; j++) begin
            if (w_ch == CH_BITS'(j)) begin
                w_rdata = w_rd_ch[j];
            end
        end
    end

    assign bus.rdata   = w_rdata;
    assign bus.irq     = w_irq;
    assign bus.irq_any = |w_irq;

endmodule

`default_nettype wire

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed scenarios plus randomized trials against a closed-form timing model.
`default_nettype none

module tb_timer_bank;
    localparam int CHANNELS = 3;
    localparam int WIDTH    = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    timer_bank_if #(.CHANNELS(CHANNELS)) bus ();

    timer_bank #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic wr(input int ch, input int rg, input logic [31:0] d);
        @(negedge clk);
        bus.addr  = 4'(ch * 4 + rg);
        bus.wdata = d;
        bus.we    = 1'b1;
        @(posedge clk);
        #1 bus.we = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int ch, input int rg, output logic [31:0] d);
        bus.addr = 4'(ch * 4 + rg);
        #1 d = bus.rdata;
    endtask

    // Expected state t edges after the enabling CTRL write (t >= 2), PS=0
    function automatic void model(input int mode, input int p, input int t,
                                  output int cnt, output bit pend, output bit en);
        int m = (mode == 3) ? 0 : mode;
        int u;
        cnt = 0; pend = 0; en = 1;
        if (m == 0) begin
            cnt  = (t - 2 >= p) ? 0 : p - (t - 2);
            pend = (t >= 3 + p);
            en   = (t < 4 + p);
        end else if (m == 1) begin
            u    = (t - 2) % (p + 3);
            cnt  = (u <= p) ? p - u : 0;
            pend = (t >= 3 + p);
        end else begin
            cnt  = (p + t - 2) % 16;
            pend = ((t - 2) >= (16 - p));
        end
    endfunction

    task automatic quiesce(input int ch);
        logic [31:0] v;
        wr(ch, 0, 32'h0);
        repeat (4) step();
        wr(ch, 3, 32'h1);
        rd(ch, 3, v);
        checks++;
        if (v !== 32'h0) begin
            failures++;
            $display("FAIL quiesce_pend ch%0d: got %0h expected 0", ch, v);
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int ch = 0; ch <= CHANNELS; ch++) begin
            for (int rg = 0; rg < 4; rg++) begin
                rd(ch, rg, v);
                checks++;
                if (v !== 32'h0) begin
                    failures++;
                    $display("FAIL reset_reg ch%0d reg%0d: got %0h expected 0", ch, rg, v);
                end
            end
        end
        checks++;
        if (bus.irq !== '0 || bus.irq_any !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq: got %b/%b expected 0/0", bus.irq, bus.irq_any);
        end
        wr(CHANNELS, 1, 32'h7);
        rd(CHANNELS, 1, v);
        checks++;
        if (v !== 32'h0) begin
            failures++;
            $display("FAIL out_of_range_write: got %0h expected 0", v);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        wr(0, 1, 32'd5);
        wr(0, 0, 32'h9);
        for (int t = 1; t <= 10; t++) begin
            step();
            if (t >= 2 && t <= 7) begin
                rd(0, 2, v);
                checks++;
                if (v !== 32'(5 - (t - 2))) begin
                    failures++;
                    $display("FAIL oneshot_count t=%0d: got %0d expected %0d", t, v, 5 - (t - 2));
                end
            end
            if (t == 7 || t == 8) begin
                checks++;
                if (bus.irq[0] !== (t == 8)) begin
                    failures++;
                    $display("FAIL oneshot_irq t=%0d: got %b expected %b", t, bus.irq[0], t == 8);
                end
            end
        end
        rd(0, 0, v);
        checks++;
        if (v !== 32'h8) begin
            failures++;
            $display("FAIL oneshot_en_clear: got %0h expected 8", v);
        end
        wr(0, 3, 32'h1);
        checks++;
        if (bus.irq[0] !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_w1c: got %b expected 0", bus.irq[0]);
        end
        quiesce(0);
    endtask

    task automatic test_autoreload();
        wr(1, 1, 32'd3);
        wr(1, 0, 32'hB);
        repeat (5) step();
        checks++;
        if (bus.irq[1] !== 1'b0) begin
            failures++;
            $display("FAIL reload_irq_edge5: got %b expected 0", bus.irq[1]);
        end
        step();
        checks++;
        if (bus.irq[1] !== 1'b1) begin
            failures++;
            $display("FAIL reload_irq_edge6: got %b expected 1", bus.irq[1]);
        end
        step();
        wr(1, 3, 32'h1);
        checks++;
        if (bus.irq[1] !== 1'b0) begin
            failures++;
            $display("FAIL reload_w1c_edge8: got %b expected 0", bus.irq[1]);
        end
        repeat (3) step();
        checks++;
        if (bus.irq[1] !== 1'b0) begin
            failures++;
            $display("FAIL reload_irq_edge11: got %b expected 0", bus.irq[1]);
        end
        wr(1, 3, 32'h1);
        checks++;
        if (bus.irq[1] !== 1'b1) begin
            failures++;
            $display("FAIL reload_set_wins_edge12: got %b expected 1", bus.irq[1]);
        end
        quiesce(1);
    endtask

    task automatic test_freerun();
        logic [31:0] v;
        wr(0, 1, 32'd14);
        wr(0, 0, 32'h5);
        for (int t = 1; t <= 4; t++) begin
            step();
            if (t >= 2) begin
                rd(0, 2, v);
                checks++;
                if (v !== 32'((14 + t - 2) % 16)) begin
                    failures++;
                    $display("FAIL freerun_count t=%0d: got %0d expected %0d", t, v, (14 + t - 2) % 16);
                end
            end
        end
        rd(0, 3, v);
        checks++;
        if (v !== 32'h1 || bus.irq[0] !== 1'b0) begin
            failures++;
            $display("FAIL freerun_wrap_pend: got pend=%0h irq=%b expected 1/0", v, bus.irq[0]);
        end
        wr(0, 0, 32'hD);
        checks++;
        if (bus.irq[0] !== 1'b1 || bus.irq_any !== 1'b1) begin
            failures++;
            $display("FAIL freerun_im_set: got %b/%b expected 1/1", bus.irq[0], bus.irq_any);
        end
        quiesce(0);
    endtask

    task automatic test_sw_wins();
        logic [31:0] v;
        wr(2, 1, 32'd0);
        wr(2, 0, 32'h1);
        repeat (2) step();
        rd(2, 3, v);
        checks++;
        if (v !== 32'h0) begin
            failures++;
            $display("FAIL preset0_pend_t2: got %0h expected 0", v);
        end
        step();
        rd(2, 3, v);
        checks++;
        if (v !== 32'h1) begin
            failures++;
            $display("FAIL preset0_pend_t3: got %0h expected 1", v);
        end
        wr(2, 0, 32'h1);
        rd(2, 0, v);
        checks++;
        if (v !== 32'h1) begin
            failures++;
            $display("FAIL sw_write_wins_en: got %0h expected 1", v);
        end
        quiesce(2);
    endtask

    task automatic test_async_reset();
        logic [31:0] c, k, s;
        wr(0, 1, 32'd5);
        wr(0, 0, 32'h9);
        repeat (5) step();
        #2 reset = 1'b1;
        rd(0, 2, c);
        rd(0, 0, k);
        rd(0, 3, s);
        checks++;
        if (c !== 0 || k !== 0 || s !== 0 || bus.irq !== '0) begin
            failures++;
            $display("FAIL async_reset: got count=%0h ctrl=%0h pend=%0h irq=%b expected all 0", c, k, s, bus.irq);
        end
        #1 reset = 1'b0;
        repeat (4) step();
        rd(0, 2, c);
        checks++;
        if (c !== 0) begin
            failures++;
            $display("FAIL post_reset_idle: got count=%0h expected 0", c);
        end
    endtask

    task automatic test_random();
        logic [31:0] v, r;
        int ch, p, mode, im, tlen, ecnt;
        bit epend, een;
        for (int it = 0; it < 12; it++) begin
            ch   = $urandom_range(0, CHANNELS - 1);
            p    = $urandom_range(0, 15);
            mode = $urandom_range(0, 3);
            im   = $urandom_range(0, 1);
            tlen = $urandom_range(6, 30);
            r    = $urandom();
            wr(ch, 1, 32'(p));
            wr(ch, 0, {r[31:8], 4'h0, 1'(im), 2'(mode), 1'b1});
            for (int t = 1; t <= tlen; t++) begin
                step();
                if (t == 1) begin
                    rd(ch, 0, v);
                    checks++;
                    if (v !== {28'd0, 1'(im), 2'(mode), 1'b1}) begin
                        failures++;
                        $display("FAIL rand_ctrl it=%0d: got %0h expected %0h", it, v, {1'(im), 2'(mode), 1'b1});
                    end
                end else begin
                    model(mode, p, t, ecnt, epend, een);
                    rd(ch, 2, v);
                    checks++;
                    if (v !== 32'(ecnt)) begin
                        failures++;
                        $display("FAIL rand_count it=%0d ch%0d mode%0d p=%0d t=%0d: got %0d expected %0d",
                                 it, ch, mode, p, t, v, ecnt);
                    end
                    rd(ch, 0, v);
                    checks++;
                    if (v[0] !== een || bus.irq[ch] !== (epend & im[0])) begin
                        failures++;
                        $display("FAIL rand_en_irq it=%0d t=%0d: got en=%b irq=%b expected en=%b irq=%b",
                                 it, t, v[0], bus.irq[ch], een, epend & im[0]);
                    end
                end
            end
            quiesce(ch);
        end
    endtask

`ifdef TIMER_BANK_PRESCALE_EN
    task automatic test_prescale();
        logic [31:0] v;
        int ec;
        wr(0, 1, 32'd2);
        wr(0, 0, 32'h21);
        for (int t = 1; t <= 14; t++) begin
            step();
            if (t == 1) begin
                rd(0, 0, v);
                checks++;
                if (v !== 32'h21) begin
                    failures++;
                    $display("FAIL prescale_ctrl: got %0h expected 21", v);
                end
            end else begin
                ec = 2 - (t - 2) / 4;
                if (ec < 0) ec = 0;
                rd(0, 2, v);
                checks++;
                if (v !== 32'(ec)) begin
                    failures++;
                    $display("FAIL prescale_count t=%0d: got %0d expected %0d", t, v, ec);
                end
                if (t >= 13) begin
                    rd(0, 3, v);
                    checks++;
                    if (v !== 32'(t == 14)) begin
                        failures++;
                        $display("FAIL prescale_pend t=%0d: got %0h expected %0d", t, v, t == 14);
                    end
                end
            end
        end
        quiesce(0);
    endtask
`else
    task automatic test_prescale();
        logic [31:0] v;
        wr(2, 0, 32'hF0);
        rd(2, 0, v);
        checks++;
        if (v !== 32'h0) begin
            failures++;
            $display("FAIL ps_bits_ignored: got %0h expected 0", v);
        end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        bus.addr  = '0;
        bus.we    = 1'b0;
        bus.wdata = 32'h0;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_freerun();
        test_sw_wins();
        test_prescale();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/timer_bank.md
# timer_bank

Parametrised multi-channel programmable timer peripheral. It is the successor to the two fixed single-channel timers hung off the data-memory bridge. It provides `CHANNELS` independent down/up counters of `WIDTH` bits behind one word-addressed register window. Each channel supports one-shot, auto-reload and free-run modes. Each channel has a sticky, maskable interrupt pending bit; per-channel and aggregate IRQ lines feed CP0 hardware interrupt inputs.

## Interface
- `CHANNELS`, default 2: number of timer channels, 1..16.
- `WIDTH`, default 32: counter/preset width, 1..32; zero-extended on `rdata`.
- `CH_BITS`, derived: max(1, clog2(`CHANNELS`)).

Ports:
- `clk`, input, 1: single clock domain.
- `reset`, input, 1: reset is asynchronous and active-high.
- `addr`, input, `CH_BITS`+2: word address {channel, reg}; reg 0 CTRL, 1 PRESET, 2 COUNT, 3 STATUS.
- `we`, input, 1: write strobe, sampled at `clk` rising edge.
- `wdata`, input, 32: write data.
- `rdata`, output, 32: combinational read of the addressed register.
- `irq`, output, `CHANNELS`: per-channel interrupt, `pending & IM`.
- `irq_any`, output, 1: OR of `irq`.

## Operation
- CTRL fields:
  - bit0 EN.
  - bits2:1 MODE: 0 one-shot, 1 auto-reload, 2 free-run, 3 treated as 0.
  - bit3 IM, interrupt mask enable.
  - bits7:4 PS, prescale; see Configuration.
  - Other bits read 0.
- PRESET: R/W, low `WIDTH` bits stored.
- COUNT: read-only; writes ignored.
- STATUS: bit0 PEND, read; writing 1 to bit0 clears it.
- Channel index ≥ `CHANNELS`: reads return 0, writes ignored.
- Per-channel FSM with states IDLE, LOAD, CNT, INT:
  - IDLE: EN=1 → LOAD.
  - LOAD: COUNT ← PRESET; prescale counter ← 0; → CNT.
  - CNT with EN=0 → IDLE; COUNT holds.
  - CNT, modes 0/1, on a tick: COUNT==0 → INT and set PEND; else COUNT ← COUNT−1.
  - CNT, mode 2, on a tick: COUNT ← COUNT+1, wrapping modulo 2^`WIDTH`. On wrap (all-ones → 0), set PEND and stay in CNT.
  - INT, mode 0: clear CTRL.EN, → IDLE.
  - INT, mode 1: → LOAD.
- A tick occurs every cycle unless prescale is active.
- MODE/IM writes take effect on the next edge. PRESET writes affect only the next LOAD.
- Arithmetic is `WIDTH`-bit unsigned with no saturation.

## Timing
- Reset values:
  - All CTRL, PRESET, COUNT and PEND = 0.
  - All FSMs in IDLE.
  - `irq` = 0, `irq_any` = 0.
  - `rdata` reflects zeroed registers.
- Register writes complete at the edge where `we`=1. `rdata` reflects the new value in the following cycle.
- One-shot latency, PS=0: CTRL write (EN=1) at edge k, PRESET=P already set.
  - Edge k+1: LOAD.
  - Edge k+2: COUNT=P.
  - Edge k+2+P: COUNT=0.
  - Edge k+3+P: PEND=1 and `irq` high if IM=1.
  - Edge k+4+P: EN=0, IDLE.
- Auto-reload: PEND is set every P+3 cycles.
- Simultaneous HW set and W1C of PEND on the same edge: set wins, PEND=1.
- A CTRL write that includes EN=1 on the same edge the FSM clears EN in INT: the software write wins.
- Reset asserted mid-count: all state clears immediately (asynchronous). Counting resumes only after reset deasserts and EN is rewritten.
- PRESET=0: PEND is set at edge k+3.

## Configuration
- `TIMER_BANK_PRESCALE_EN` defined:
  - CTRL bits7:4 are R/W.
  - Each channel has a 15-bit prescale counter, cleared in LOAD.
  - In CNT a tick occurs when the prescale counter == 2^PS−1; the counter then returns to 0, otherwise it increments.
- Not defined:
  - Bits7:4 read 0 and writes are ignored.
  - Every CNT cycle is a tick.
  - No prescale registers are instantiated.

## Test plan
- Reset then read every register of channels 0..`CHANNELS`−1 → all 0, `irq`=0. Read an out-of-range channel → 0.
- Ch0: PRESET=5, CTRL=0x9 (EN, mode 0, IM) → PEND and `irq[0]` high exactly 8 edges after the CTRL write. COUNT reads 5,4,…,0. EN reads 0 afterward. W1C STATUS → `irq[0]` low.
- Ch1: PRESET=3, CTRL=0xB (mode 1, IM) → PEND set at edge 6. W1C on the same edge as the second set (edge 12) → PEND stays 1.
- `WIDTH`=4, ch0 mode 2, PRESET=14, IM=0 → COUNT 14,15,0 and PEND=1 with `irq`=0. Set IM → `irq[0]`=1 and `irq_any`=1.
- Assert `reset` asynchronously mid-count (COUNT=2) → COUNT, CTRL and PEND are 0 before the next clock edge.
- With `TIMER_BANK_PRESCALE_EN`: PRESET=2, PS=2, mode 0 → COUNT decrements every 4 cycles. PEND is set 12 cycles after entering CNT.
